// File: rtl/serial_shift_right.sv
// serial_shift_right: multi-cycle right shifter. It shifts one bit per clock, in logical
// (zero-fill) or arithmetic (sign-fill) mode.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   start  - request pulse; accepted only while idle
//   arith  - 1 = arithmetic shift, 0 = logical shift; captured with start
//   in     - operand, captured with start
//   shamt  - shift amount, captured with start
//   busy   - high while a request is being processed (SHIFT and DONE)
//   done   - one-cycle completion pulse
//   out    - registered result; holds until the next completion
module serial_shift_right #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] in,
    input  logic [SW-1:0]    shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             fill_q,  fill_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        work_d  = work_q;
        out_d   = out_q;
        fill_d  = fill_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = in;
                    count_d = shamt;
                    // The sign bit is only replicated for arithmetic shifts.
                    fill_d  = arith & in[WIDTH-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q != '0) begin
                    work_d  = {fill_q, work_q[WIDTH-1:1]};
                    count_d = count_q - SW'(1);
                end else begin
                    out_d   = work_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy and done are registered, so they are derived from the state being entered.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            work_q  <= '0;
            out_q   <= '0;
            fill_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            work_q  <= work_d;
            out_q   <= out_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_serial_shift_right.sv
// tb_serial_shift_right: directed and random stimulus for serial_shift_right. A
// cycle-count model predicts busy, done and out on every cycle.
module tb_serial_shift_right;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SW    = 5;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             arith = 1'b0;
    logic [WIDTH-1:0] din   = '0;
    logic [SW-1:0]    shamt = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_shift_right #(.WIDTH(WIDTH), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .arith (arith),
        .in    (din),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .out   (dout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                              input logic ar);
        if (ar) return 32'($signed(a) >>> s);
        else    return a >> s;
    endfunction

    // Model: m_left counts the busy cycles still to come. An accepted request is busy
    // for shamt+2 cycles, and the final one of those cycles is the done cycle.
    int          m_left = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_out  = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_out  <= '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= int'(shamt) + 2;
                m_res  <= ref_shift(din, shamt, arith);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_out <= m_res;
        end
    end

    // Compare the DUT with the model in the middle of every cycle.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_left > 0));
        check("done", 32'(done), 32'(m_left == 1));
        check("out", dout, m_out);
    end

    // Start one request. Then scramble the inputs and wait for done.
    task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic ar,
                          output logic [31:0] res, output int lat);
        @(posedge clk); #1;
        din = a; shamt = s; arith = ar; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din   = $urandom;
        shamt = 5'($urandom);
        arith = 1'($urandom);
        lat = 0;
        res = 'x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                res = dout;
                break;
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles for in=%h shamt=%0d", lat, a, s);
        end
    endtask

    logic [31:0] res;
    int          lat;
    int          ndone;

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", dout, 32'd0);
        reset = 1'b0;

        // Logical shift.
        run_op(32'hF000_0000, 5'd4, 1'b0, res, lat);
        check("lsr_out", res, 32'h0F00_0000);
        check("lsr_lat", 32'(lat), 32'd6);

        // Arithmetic shift and logical shift of the same operand.
        run_op(32'h8000_0010, 5'd4, 1'b1, res, lat);
        check("asr_out", res, 32'hF800_0001);
        run_op(32'h8000_0010, 5'd4, 1'b0, res, lat);
        check("asr_as_lsr_out", res, 32'h0800_0001);

        // Zero and maximum shift amounts.
        run_op(32'h1234_5678, 5'd0, 1'b0, res, lat);
        check("zero_out", res, 32'h1234_5678);
        check("zero_lat", 32'(lat), 32'd2);
        run_op(32'h8000_0000, 5'd31, 1'b1, res, lat);
        check("max_asr_out", res, 32'hFFFF_FFFF);
        check("max_asr_lat", 32'(lat), 32'd33);
        run_op(32'h8000_0000, 5'd31, 1'b0, res, lat);
        check("max_lsr_out", res, 32'h0000_0001);

        // A start while busy is ignored.
        @(posedge clk); #1;
        din = 32'h0000_0100; shamt = 5'd8; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        din = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("busy_start_ndone", 32'(ndone), 32'd1);
        check("busy_start_out", dout, 32'h0000_0001);

        // A start in the DONE cycle is ignored.
        run_op(32'h0000_00F0, 5'd4, 1'b0, res, lat);
        check("done_start_first", res, 32'h0000_000F);
        din = 32'hFFFF_FFFF; shamt = 5'd3; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("done_start_busy", 32'(busy), 32'd0);
        check("done_start_out", dout, 32'h0000_000F);

        // Reset in the middle of a shift.
        @(posedge clk); #1;
        din = 32'hAAAA_5555; shamt = 5'd10; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_out", dout, 32'd0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        run_op(32'h0000_0040, 5'd2, 1'b0, res, lat);
        check("post_rst_out", res, 32'h0000_0010);
        check("post_rst_lat", 32'(lat), 32'd4);

        // Random operands.
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] a;
            logic [4:0]  s;
            logic        ar;
            a  = $urandom;
            s  = 5'($urandom_range(0, 31));
            ar = 1'($urandom);
            run_op(a, s, ar, res, lat);
            check("rand_out", res, ref_shift(a, s, ar));
            check("rand_lat", 32'(lat), 32'(s) + 32'd2);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
